// File: rtl/mscnt.sv
// Free-running millisecond-style tick counter: a prescaler divides clk down to
// TICK_HZ and a 32-bit count advances once per prescaler period.
module mscnt #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned WRAP    = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] cnt
);

    localparam int unsigned CYCLES = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CYCLES - 1);

    generate
        if (CYCLES < 1) begin : g_bad_cycles
            $error("mscnt: CLK_HZ / TICK_HZ must be at least 1");
        end
    endgenerate

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [31:0]      cnt_q, cnt_d;

    // Overflow policy applied at the top of the 32-bit range.
    function automatic logic [31:0] advance(input logic [31:0] c);
        if (c == 32'hFFFF_FFFF) begin
            return (WRAP != 0) ? 32'h0000_0000 : c;
        end
        return c + 32'd1;
    endfunction

    always_comb begin
        pre_d = pre_q + 1'b1;
        cnt_d = cnt_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            cnt_d = advance(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_mscnt.sv
// Directed bench for mscnt: four instances with different prescale/overflow
// settings checked every cycle against an arithmetic elapsed-time model.
module tb_mscnt;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cnt_a, cnt_b, cnt_c, cnt_d;

    always #5 clk = ~clk;

    mscnt #(.CLK_HZ(10000), .TICK_HZ(1000), .WRAP(1)) dut_a (.clk(clk), .reset(reset), .cnt(cnt_a));
    mscnt #(.CLK_HZ(1000),  .TICK_HZ(1000), .WRAP(1)) dut_b (.clk(clk), .reset(reset), .cnt(cnt_b));
    mscnt #(.CLK_HZ(1000),  .TICK_HZ(1000), .WRAP(0)) dut_c (.clk(clk), .reset(reset), .cnt(cnt_c));
    mscnt dut_d (.clk(clk), .reset(reset), .cnt(cnt_d));

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    // Model: count = base + floor(edges/CYCLES) - floor(edges at deposit/CYCLES)
    longint unsigned n_edges = 0;
    longint unsigned cyc[4]  = '{10, 1, 1, 100000};
    bit              wrp[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    longint unsigned base[4] = '{0, 0, 0, 0};
    longint unsigned k0[4]   = '{0, 0, 0, 0};

    function automatic logic [31:0] model_cnt(input int i);
        longint unsigned v;
        v = base[i] + n_edges / cyc[i] - k0[i];
        if (wrp[i]) return v[31:0];
        if (v > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
        return v[31:0];
    endfunction

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return cnt_a;
            1:       return cnt_b;
            2:       return cnt_c;
            default: return cnt_d;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic lit(input string nm, input int i, input logic [31:0] v);
        chk($sformatf("%s dut%0d", nm, i), dut_cnt(i), v);
        chk($sformatf("%s model%0d", nm, i), model_cnt(i), v);
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            started = 1'b1;
            n_edges = 0;
            for (int i = 0; i < 4; i++) begin
                base[i] = 0;
                k0[i]   = 0;
            end
        end else begin
            n_edges++;
        end
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("cycle@%0t dut%0d", $time, i), dut_cnt(i), model_cnt(i));
            end
        end
    endtask

    task automatic deposit_top();
        force dut_b.cnt_q = 32'hFFFF_FFFE;
        force dut_c.cnt_q = 32'hFFFF_FFFE;
        for (int i = 1; i < 3; i++) begin
            base[i] = 64'h0000_0000_FFFF_FFFE;
            k0[i]   = n_edges / cyc[i];
        end
        #1;
        release dut_b.cnt_q;
        release dut_c.cnt_q;
    endtask

    initial begin
        // Initial reset held for two edges
        reset = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) lit("reset", i, 32'd0);

        // Basic count, and single-cycle prescale on the CYCLES=1 instances
        reset = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e <= 3) begin
                lit("cyc1 wrap", 1, 32'(e));
                lit("cyc1 sat", 2, 32'(e));
            end
        end
        lit("basic edge9", 0, 32'd0);
        step();
        lit("basic edge10", 0, 32'd1);
        repeat (40) step();
        lit("basic edge50", 0, 32'd5);
        lit("default params", 3, 32'd0);

        // Reset pulse between edges must be ignored
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        step();
        lit("glitch", 0, 32'd5);
        lit("glitch", 1, 32'd51);

        // Mid-interval reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (34) step();
        lit("mid pre", 0, 32'd3);
        reset = 1'b0;
        step();
        lit("mid reset", 0, 32'd0);
        reset = 1'b1;
        repeat (9) step();
        lit("mid edge9", 0, 32'd0);
        step();
        lit("mid edge10", 0, 32'd1);

        // Reset coincident with prescaler at CYCLES-1
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (9) step();
        lit("coinc pre", 0, 32'd0);
        reset = 1'b0;
        step();
        lit("coinc", 0, 32'd0);

        // Reset held for several edges
        repeat (3) step();
        lit("held", 0, 32'd0);
        lit("held", 1, 32'd0);
        reset = 1'b1;

        // Wrap and saturate around the top of the range
        repeat (5) step();
        deposit_top();
        step();
        lit("top+1", 1, 32'hFFFF_FFFF);
        lit("top+1", 2, 32'hFFFF_FFFF);
        step();
        lit("wrap0", 1, 32'h0000_0000);
        lit("sat", 2, 32'hFFFF_FFFF);
        step();
        lit("wrap1", 1, 32'h0000_0001);
        lit("sat", 2, 32'hFFFF_FFFF);
        repeat (3) step();
        lit("wrap4", 1, 32'h0000_0004);
        lit("sat hold", 2, 32'hFFFF_FFFF);

        // Reset out of saturation
        reset = 1'b0;
        step();
        lit("sat reset", 2, 32'd0);
        reset = 1'b1;
        step();
        lit("sat restart", 2, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mscnt.md
MSCNT -- requirements
Module: mscnt

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz (10 ns period).
REQ-002 Parameter TICK_HZ, default 1000, count-increment rate in Hz (1 ms per count).
REQ-003 Parameter WRAP, default 1, overflow policy: 1 = wrap to zero, 0 = saturate at all-ones.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 cnt  output  32  elapsed tick count since the last reset, unsigned.
REQ-007 Port order SHALL be clk, reset, cnt, so that positional instantiation works; no other ports.

Function
REQ-008 CYCLES SHALL be derived as CLK_HZ / TICK_HZ (integer division, truncating).
- CYCLES < 1 is an elaboration-time error.
REQ-009 The prescaler SHALL be an internal counter sized to hold CYCLES-1, with a minimum width of 1 bit.
REQ-010 Each rising clk edge with reset high, prescaler below CYCLES-1 -> prescaler increments; cnt holds.
REQ-011 Each rising clk edge with reset high, prescaler at CYCLES-1 -> prescaler returns to 0 and cnt advances by one on that same edge.
REQ-012 cnt SHALL be a registered output with no combinational path from any input.
REQ-013 First increment timing:
- cnt reads 1 after exactly CYCLES rising edges with reset high, counting from the first edge after reset deasserts.
- cnt reads N after N*CYCLES such edges.
REQ-014 CYCLES = 1 -> cnt increments on every rising edge with reset high.
REQ-015 WRAP = 1: advancing from 0xFFFFFFFF SHALL yield 0x00000000; the prescaler continues unaffected.
REQ-016 WRAP = 0: cnt SHALL hold 0xFFFFFFFF once reached; the prescaler keeps cycling.
REQ-017 No other input affects counting; there is no enable, load or pause.

Reset
REQ-018 reset low at a rising clk edge SHALL set cnt to 0x00000000 and the prescaler to 0.
REQ-019 Reset SHALL take priority over a coincident increment.
- If reset is low on the edge where the prescaler is at CYCLES-1, the result is cnt = 0 and prescaler = 0.
REQ-020 Reset is sampled only at rising clk edges.
- A reset pulse that does not span a rising edge has no effect.
- cnt SHALL NOT change asynchronously.
REQ-021 Reset asserted mid-interval SHALL discard partial prescaler progress.
- After release, the next increment needs a full CYCLES edges.
REQ-022 Holding reset low for any number of edges SHALL keep cnt at 0.
REQ-023 Before the first reset edge, cnt is unspecified.
- Benches SHALL apply reset for at least one rising edge before checking outputs.

Verification
REQ-024 Basic count: CLK_HZ=10000, TICK_HZ=1000 (CYCLES=10); reset low for 2 edges, then high.
- cnt = 0 through edge 9 after release.
- cnt = 1 after edge 10.
- cnt = 5 after edge 50.
REQ-025 Mid-interval reset: CYCLES=10; run to cnt = 3 plus 4 extra edges, then drive reset low for 1 edge, then high.
- cnt = 0 immediately after the reset edge.
- cnt = 1 exactly 10 edges after release.
REQ-026 Coincident reset: CYCLES=10; assert reset on the edge where the prescaler is at 9.
- cnt = 0 after that edge, never 1.
REQ-027 Single-cycle prescale: CLK_HZ=TICK_HZ=1000 (CYCLES=1); release reset.
- cnt = 1, 2, 3 after edges 1, 2, 3.
REQ-028 Wrap: WRAP=1, CYCLES=1; force cnt near the top via a hierarchical deposit of 0xFFFFFFFE.
- Next edges give 0xFFFFFFFF, then 0x00000000, then 0x00000001.
REQ-029 Saturate: WRAP=0, CYCLES=1; same deposit of 0xFFFFFFFE.
- Next edges give 0xFFFFFFFF, then 0xFFFFFFFF held for at least 3 more edges.
